// File: rtl/ctrl_pkg.sv
// Shared control-bundle types, opcode table and field encodings for the 5-stage control pipe.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ctrl_pkg;

  // Field encodings
  localparam logic [2:0] RW_NONE = 3'b000;
  localparam logic [2:0] RW_WORD = 3'b001;
  localparam logic [2:0] RW_HALF = 3'b010;
  localparam logic [2:0] RW_BYTE = 3'b011;
  localparam logic [2:0] RW_LINK = 3'b100;
  localparam logic [2:0] RW_MAC  = 3'b101;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_WORD = 2'b01;
  localparam logic [1:0] MW_HALF = 2'b10;
  localparam logic [1:0] MW_BYTE = 2'b11;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC  = 2'b10;

  // ALU operations (R-type funct[3:0] uses the same numbering for 0..9)
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_MUL  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  // Opcode table
  localparam logic [6:0] OP_R     = 7'h01;
  localparam logic [6:0] OP_ADDI  = 7'h02;
  localparam logic [6:0] OP_ANDI  = 7'h03;
  localparam logic [6:0] OP_ORI   = 7'h04;
  localparam logic [6:0] OP_XORI  = 7'h05;
  localparam logic [6:0] OP_SLLI  = 7'h06;
  localparam logic [6:0] OP_SRLI  = 7'h07;
  localparam logic [6:0] OP_SRAI  = 7'h08;
  localparam logic [6:0] OP_SLTI  = 7'h09;
  localparam logic [6:0] OP_MULI  = 7'h0A;
  localparam logic [6:0] OP_LW    = 7'h0B;
  localparam logic [6:0] OP_LH    = 7'h0C;
  localparam logic [6:0] OP_LB    = 7'h0D;
  localparam logic [6:0] OP_SW    = 7'h0E;
  localparam logic [6:0] OP_SH    = 7'h0F;
  localparam logic [6:0] OP_SB    = 7'h10;
  localparam logic [6:0] OP_LUI   = 7'h11;
  localparam logic [6:0] OP_BEQ   = 7'h12;
  localparam logic [6:0] OP_BNE   = 7'h13;
  localparam logic [6:0] OP_BGE   = 7'h14;
  localparam logic [6:0] OP_BLT   = 7'h15;
  localparam logic [6:0] OP_JAL   = 7'h16;
  localparam logic [6:0] OP_JALR  = 7'h17;
  localparam logic [6:0] OP_SAJ   = 7'h18;
  localparam logic [6:0] OP_MA    = 7'h19;
  localparam logic [6:0] OP_SLTIU = 7'h1A;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic       mem_read;
    logic [1:0] mem_write;
    logic [1:0] mem_to_reg;
    logic [2:0] reg_write;
    logic       alu_src;
    logic [3:0] alu_op1;
    logic [3:0] alu_op2;
    logic       br_eq;
    logic       br_ne;
    logic       br_ge;
    logic       br_lt;
    logic       jump;
    logic       jump_reg;
    logic       saj;
    logic       is_mul;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  typedef enum logic {ST_RUN, ST_MUL_BUSY} state_t;

  // ALU operation for the register-immediate arithmetic opcodes
  function automatic logic [3:0] imm_alu_op(input logic [6:0] op);
    logic [3:0] r;
    r = ALU_ADD;
    case (op)
      OP_ANDI:  r = ALU_AND;
      OP_ORI:   r = ALU_OR;
      OP_XORI:  r = ALU_XOR;
      OP_SLLI:  r = ALU_SLL;
      OP_SRLI:  r = ALU_SRL;
      OP_SRAI:  r = ALU_SRA;
      OP_SLTI:  r = ALU_SLT;
      OP_SLTIU: r = ALU_SLTU;
      default:  r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ctrl_pipe_decode.sv
// ID-stage decoder: opcode/funct to control bundle; anything unrecognised becomes NOP.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is captured.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic       valid,
  input  logic [6:0] opcode,
  input  logic [9:0] funct,
  output ctrl_t      ctrl
);

  // Table decode; R-type funct with nonzero upper bits is treated as unknown
  always_comb begin
    ctrl = CTRL_NOP;
    if (valid) begin
      case (opcode)
        OP_R: begin
          if (funct[9:4] == 6'd0 && funct[3:0] <= ALU_SLT) begin
            ctrl.reg_write = RW_WORD;
            ctrl.alu_op1   = funct[3:0];
            ctrl.is_mul    = (funct[3:0] == ALU_MUL);
          end
        end
        OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU: begin
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = RW_WORD;
          ctrl.alu_op1   = imm_alu_op(opcode);
        end
        OP_MULI: begin
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = RW_WORD;
          ctrl.alu_op1   = ALU_MUL;
          ctrl.is_mul    = 1'b1;
        end
        OP_LW, OP_LH, OP_LB: begin
          ctrl.mem_read   = 1'b1;
          ctrl.mem_to_reg = MTR_MEM;
          ctrl.alu_src    = 1'b1;
          ctrl.alu_op1    = ALU_ADD;
          ctrl.reg_write  = (opcode == OP_LW) ? RW_WORD :
                            (opcode == OP_LH) ? RW_HALF : RW_BYTE;
        end
        OP_SW, OP_SH, OP_SB: begin
          ctrl.alu_src   = 1'b1;
          ctrl.alu_op1   = ALU_ADD;
          ctrl.mem_write = (opcode == OP_SW) ? MW_WORD :
                           (opcode == OP_SH) ? MW_HALF : MW_BYTE;
        end
        OP_LUI: begin
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = RW_WORD;
          ctrl.alu_op1   = ALU_LUI;
        end
        OP_BEQ: begin ctrl.br_eq = 1'b1; ctrl.alu_op1 = ALU_SUB; end
        OP_BNE: begin ctrl.br_ne = 1'b1; ctrl.alu_op1 = ALU_SUB; end
        OP_BGE: begin ctrl.br_ge = 1'b1; ctrl.alu_op1 = ALU_SLT; end
        OP_BLT: begin ctrl.br_lt = 1'b1; ctrl.alu_op1 = ALU_SLT; end
        OP_JAL: begin
          ctrl.jump       = 1'b1;
          ctrl.reg_write  = RW_LINK;
          ctrl.mem_to_reg = MTR_PC;
        end
        OP_JALR: begin
          ctrl.jump_reg   = 1'b1;
          ctrl.alu_src    = 1'b1;
          ctrl.alu_op1    = ALU_ADD;
          ctrl.reg_write  = RW_LINK;
          ctrl.mem_to_reg = MTR_PC;
        end
        OP_SAJ: begin
          // store the link value and jump in one instruction
          ctrl.saj       = 1'b1;
          ctrl.jump      = 1'b1;
          ctrl.alu_src   = 1'b1;
          ctrl.alu_op1   = ALU_ADD;
          ctrl.mem_write = MW_WORD;
        end
        OP_MA: begin
          ctrl.reg_write = RW_MAC;
          ctrl.alu_op1   = ALU_MUL;
          ctrl.alu_op2   = ALU_ADD;
          ctrl.is_mul    = 1'b1;
        end
        default: ctrl = CTRL_NOP;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline EX/MEM/WB with load-use bubble, multi-cycle multiply hold and flush.
// Latency: one edge per stage; multiplies occupy EX for MUL_LAT cycles.
// Backpressure: mem_stall_i freezes everything; stall_o holds PC and IF/ID.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [6:0]        id_opcode_i,
  input  logic [9:0]        id_funct12_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              flush_i,
  input  logic              mem_stall_i,
  output logic              stall_o,
  output ctrl_t             ex_ctrl_o,
  output ctrl_t             mem_ctrl_o,
  output ctrl_t             wb_ctrl_o,
  output logic [REG_AW-1:0] ex_rd_o
);

  ctrl_t             id_ctrl;
  ctrl_t             ex_q, mem_q, wb_q;
  logic [REG_AW-1:0] ex_rd_q;
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              kill_pend;
  logic              load_use;
  logic              busy;

  ctrl_decode u_decode (
    .valid  (id_valid_i),
    .opcode (id_opcode_i),
    .funct  (id_funct12_i),
    .ctrl   (id_ctrl)
  );

  assign busy     = (state == ST_MUL_BUSY);
  assign load_use = ex_q.mem_read && (ex_rd_q != '0) &&
                    ((ex_rd_q == id_rs1_i) || (ex_rd_q == id_rs2_i));
  // flush cancels the ID instruction anyway, so a load-use stall would only waste a cycle
  assign stall_o  = rst_n && (mem_stall_i || busy || (!flush_i && load_use));

  assign ex_ctrl_o  = ex_q;
  assign mem_ctrl_o = mem_q;
  assign wb_ctrl_o  = wb_q;
  assign ex_rd_o    = ex_rd_q;

  // Stage registers and RUN/MUL_BUSY sequencing; a frozen memory stalls every register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= CTRL_NOP;
      mem_q     <= CTRL_NOP;
      wb_q      <= CTRL_NOP;
      ex_rd_q   <= '0;
      state     <= ST_RUN;
      cnt       <= '0;
      kill_pend <= 1'b0;
    end else if (!mem_stall_i) begin
      wb_q <= mem_q;
      if (busy) begin
        // multiply held in EX; remember a flush so the waiting ID instruction is dropped later
        mem_q <= CTRL_NOP;
        cnt   <= cnt - 1'b1;
        if (flush_i) kill_pend <= 1'b1;
        if (cnt == CNT_W'(1)) state <= ST_RUN;
      end else begin
        mem_q     <= ex_q;
        kill_pend <= 1'b0;
        if (flush_i || kill_pend || load_use) begin
          ex_q    <= CTRL_NOP;
          ex_rd_q <= '0;
        end else begin
          ex_q    <= id_ctrl;
          ex_rd_q <= id_valid_i ? id_rd_i : '0;
          if (id_ctrl.is_mul && MUL_LAT > 1) begin
            state <= ST_MUL_BUSY;
            cnt   <= CNT_W'(MUL_LAT - 1);
          end
        end
      end
    end
  end

endmodule
